tnn_feature_loader: RTL and testbench
=====================================

Name: tnn_feature_loader

Overview:
- Input stage directly upstream of the 7-input, 2-bit-per-feature approximate TNN classifier (inputs a..g, 1-bit class output).
- Accepts raw 8-bit feature samples serially over a valid/ready stream and quantizes each to 2 bits with per-feature thresholds.
- Assembles a 7-feature frame, drives the classifier inputs stably, captures its 1-bit decision and returns it on a valid/ready result stream.

Parameters:
- NFEAT, 7, features per frame; fixed to match the classifier input count.
- THR_VEC, {7{8'd192,8'd128,8'd64}}, packed per-feature thresholds. Feature k (k=0 is a) uses bits [24k+23:24k] = {T2,T1,T0}, each unsigned 8-bit.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  raw sample valid.
- in_ready  out  1  loader can accept a sample.
- in_data  in  8  raw unsigned feature value.
- in_last  in  1  marks the final sample of a frame.
- feat_a..feat_g  out  2 each  quantized features to the classifier.
- cls_result  in  1  classifier output, combinational from feat_*.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  1  captured classifier decision.
- out_err  out  1  framing error flag, qualified by out_valid.

Behaviour:
- Reset: synchronous, active-low. All outputs are 0 at reset: in_ready=0 during reset, then 1 on the first cycle after rst_n rises. The index counter and all feature registers are cleared; the FSM returns to COLLECT.
- Reset is honoured in any state. A partial frame or a pending result is discarded with no output.
- Quantization of x with thresholds {T2,T1,T0}:
  - q=0 if x<T0
  - q=1 if T0<=x<T1
  - q=2 if T1<=x<T2
  - q=3 otherwise
  - Comparisons are unsigned. Misordered thresholds give a priority result: check x>=T2 first, then x>=T1, then x>=T0.
- A sample is accepted only when in_valid && in_ready. The quantized value is written to feature register idx, then idx increments. idx is 3 bits, range 0..6.
- FSM, states COLLECT, EVAL, HOLD:
  - COLLECT: in_ready=1. On an accepted sample with idx==6 and in_last=1, go to EVAL and reset idx to 0.
  - COLLECT, short frame: in_last=1 with idx<6. Flag err, clear idx, go to EVAL with the feature registers as they stand. Unwritten registers keep their previous-frame values.
  - COLLECT, long frame: idx==6 with in_last=0. Flag err, clear idx, go to EVAL.
  - EVAL: in_ready=0. feat_* are stable. At the end of this cycle, register out_class<=cls_result and out_err<=err, then go to HOLD.
  - HOLD: out_valid=1; out_class and out_err are stable. in_ready=0. When out_ready=1, clear out_valid and err and go to COLLECT.
- feat_* are driven directly from the feature registers. They change only on accepted samples, never in EVAL or HOLD.
- Latency: the result is valid 2 cycles after the clock edge that accepts the last sample. No sample may be accepted in the HOLD exit cycle; in_ready rises on the following cycle.
- Throughput: one frame per NFEAT+2 cycles when out_ready is held at 1.
- Stalls: in_valid may be deasserted mid-frame for any number of cycles; the state is held.
- out_ready=1 outside HOLD is ignored.

Optional Feature:
- Macro TNN_LOADER_CLS_PIPE_EN.
- Defined: EVAL lasts 2 cycles (an EVAL2 substate) and cls_result is sampled on the second cycle. This supports a classifier with one output register. Latency becomes 3 cycles; throughput is one frame per NFEAT+3 cycles.
- Undefined: single-cycle EVAL as described in Behaviour.

Test Plan:
- Default thresholds. Send 10,70,130,200,63,64,255 with in_last on the 7th sample -> feat_a..g = 0,1,2,3,0,1,3. out_valid rises 2 cycles after the last acceptance. out_class equals cls_result, out_err=0.
- Gaps: in_valid toggles 1,0,0,1,... through a frame -> same packed features and latency counted from the last acceptance; in_ready=0 throughout EVAL/HOLD.
- Short frame: 4 samples, in_last on the 4th -> out_valid with out_err=1. The next good frame gives out_err=0.
- Long frame: 7 samples with no in_last -> out_err=1 after the 7th. The 8th sample is not accepted until after HOLD exits.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_valid, out_class and feat_* stay stable and in_ready stays 0. After out_ready=1, in_ready=1 on the next cycle.
- Reset: assert rst_n=0 after 3 samples -> all outputs 0 the following cycle. The next full frame produces correct results with idx starting at 0.

Source files
------------

// File: rtl/tnn_feature_loader.sv
// tnn_feature_loader: quantizes serial 8-bit samples into a 7-feature frame for the TNN classifier and returns its decision.
// Define TNN_LOADER_CLS_PIPE_EN to hold the frame for a second evaluation cycle (registered classifier output).
module tnn_feature_loader #(
    parameter int NFEAT = 7,
    parameter logic [24*NFEAT-1:0] THR_VEC = {7{8'd192, 8'd128, 8'd64}}
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic [1:0] feat_a,
    output logic [1:0] feat_b,
    output logic [1:0] feat_c,
    output logic [1:0] feat_d,
    output logic [1:0] feat_e,
    output logic [1:0] feat_f,
    output logic [1:0] feat_g,
    input  logic       cls_result,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_class,
    output logic       out_err
);
    typedef enum logic [1:0] {
        COLLECT,
        EVAL,
`ifdef TNN_LOADER_CLS_PIPE_EN
        EVAL2,
`endif
        HOLD
    } state_t;

`ifdef TNN_LOADER_CLS_PIPE_EN
    localparam state_t CAPTURE = EVAL2;
`else
    localparam state_t CAPTURE = EVAL;
`endif

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] feat_q [NFEAT];
    logic [1:0] feat_n [NFEAT];
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic       out_class_q, out_class_d;
    logic       out_err_q, out_err_d;
    logic       err_q, err_d;
    logic       accept, at_last_idx, frame_end;

    // Priority order makes misordered thresholds resolve toward the highest level.
    function automatic logic [1:0] quant(input logic [7:0] x, input logic [23:0] thr);
        return (x >= thr[23:16]) ? 2'd3 : (x >= thr[15:8]) ? 2'd2 : (x >= thr[7:0]) ? 2'd1 : 2'd0;
    endfunction

    assign accept      = in_valid && in_ready_q;
    assign at_last_idx = idx_q == 3'(NFEAT - 1);
    assign frame_end   = in_last || at_last_idx;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        out_class_d = out_class_q;
        out_err_d   = out_err_q;
        for (int k = 0; k < NFEAT; k++)
            feat_n[k] = (accept && idx_q == 3'(k)) ? quant(in_data, THR_VEC[24*k +: 24]) : feat_q[k];
        case (state_q)
            COLLECT: if (accept) begin
                idx_d = frame_end ? 3'd0 : idx_q + 3'd1;
                if (frame_end) begin
                    state_d = EVAL;
                    err_d   = in_last != at_last_idx;
                end
            end
`ifdef TNN_LOADER_CLS_PIPE_EN
            EVAL:    state_d = EVAL2;
            EVAL2:   state_d = HOLD;
`else
            EVAL:    state_d = HOLD;
`endif
            HOLD: if (out_ready) begin
                state_d = COLLECT;
                err_d   = 1'b0;
            end
            default: state_d = COLLECT;
        endcase
        if (state_q == CAPTURE) begin
            out_class_d = cls_result;
            out_err_d   = err_q;
        end
        in_ready_d  = state_d == COLLECT;
        out_valid_d = state_d == HOLD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            idx_q       <= 3'd0;
            feat_q      <= '{default: 2'd0};
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= 1'b0;
            out_err_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            feat_q      <= feat_n;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_err_q   <= out_err_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_err   = out_err_q;
    assign feat_a    = feat_q[0];
    assign feat_b    = feat_q[1];
    assign feat_c    = feat_q[2];
    assign feat_d    = feat_q[3];
    assign feat_e    = feat_q[4];
    assign feat_f    = feat_q[5];
    assign feat_g    = feat_q[6];
endmodule

// File: tb/tb_tnn_feature_loader.sv
// tb_tnn_feature_loader: directed checks of quantization, framing errors, latency, backpressure and reset.
// A parity function of the features stands in for the classifier.
module tb_tnn_feature_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic [1:0] feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g;
    logic       cls_result;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_class;
    logic       out_err;
    int         n_chk = 0;
    int         n_fail = 0;

    tnn_feature_loader dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .feat_a(feat_a), .feat_b(feat_b), .feat_c(feat_c), .feat_d(feat_d),
        .feat_e(feat_e), .feat_f(feat_f), .feat_g(feat_g),
        .cls_result(cls_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err)
    );

    assign cls_result = ^{feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g};

    always #5 clk = ~clk;

    function automatic logic [13:0] feats();
        return {feat_g, feat_f, feat_e, feat_d, feat_c, feat_b, feat_a};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits gap idle cycles, then presents one sample until it is accepted; returns 1ns after that edge.
    task automatic send(input logic [7:0] d, input logic l, input int gap);
        int n = 0;
        repeat (gap + 1) @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", 16'(in_ready), 16'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called 1ns after the last accepting edge: checks EVAL, HOLD (with hold stall cycles) and HOLD exit.
    task automatic expect_result(input string tag, input logic [13:0] f, input logic c, input logic e, input int hold);
        check({tag, "_eval_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_eval_ready"}, 16'(in_ready), 16'd0);
        check({tag, "_feats"}, 16'(feats()), 16'(f));
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 16'(out_valid), 16'd1);
        check({tag, "_class"}, 16'(out_class), 16'(c));
        check({tag, "_err"}, 16'(out_err), 16'(e));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_stall_valid"}, 16'(out_valid), 16'd1);
            check({tag, "_stall_class"}, 16'(out_class), 16'(c));
            check({tag, "_stall_feats"}, 16'(feats()), 16'(f));
            check({tag, "_stall_ready"}, 16'(in_ready), 16'd0);
        end
        check({tag, "_hold_ready"}, 16'(in_ready), 16'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_exit_valid"}, 16'(out_valid), 16'd0);
        check({tag, "_exit_ready"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        logic [7:0] f1 [7];
        logic [7:0] f2 [7];
        f1 = '{8'd10, 8'd70, 8'd130, 8'd200, 8'd63, 8'd64, 8'd255};
        f2 = '{8'd191, 8'd192, 8'd127, 8'd128, 8'd63, 8'd64, 8'd0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 16'(in_ready), 16'd0);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_class", 16'(out_class), 16'd0);
        check("rst_out_err", 16'(out_err), 16'd0);
        check("rst_feats", 16'(feats()), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 16'(in_ready), 16'd1);

        // features 0,1,2,3,0,1,3 ; parity 1 ; plus 5 stall cycles in HOLD
        for (int i = 0; i < 7; i++) send(f1[i], i == 6, 0);
        expect_result("basic", 14'b11_01_00_11_10_01_00, 1'b1, 1'b0, 5);

        // same frame with idle gaps between samples
        for (int i = 0; i < 7; i++) begin
            send(f1[i], i == 6, (i % 2 == 0) ? 2 : 0);
            if (i == 2) check("gap_mid_feats", 16'(feats() & 14'h3f), 16'(14'b10_01_00));
        end
        expect_result("gaps", 14'b11_01_00_11_10_01_00, 1'b1, 1'b0, 0);

        // short frame: a..d = 3,0,1,2, e..g keep 0,1,3
        send(8'd255, 1'b0, 0);
        send(8'd0, 1'b0, 0);
        send(8'd64, 1'b0, 0);
        send(8'd128, 1'b1, 0);
        expect_result("short", 14'b11_01_00_10_01_00_11, 1'b1, 1'b1, 0);

        // good frame at threshold edges: 2,3,1,2,0,1,0 ; parity 0
        for (int i = 0; i < 7; i++) send(f2[i], i == 6, 0);
        expect_result("good", 14'b00_01_00_10_01_11_10, 1'b0, 1'b0, 0);

        // long frame: seven 64s with no in_last, then an 8th sample waits out HOLD
        for (int i = 0; i < 7; i++) send(8'd64, 1'b0, 0);
        check("long_eval_valid", 16'(out_valid), 16'd0);
        check("long_eval_ready", 16'(in_ready), 16'd0);
        in_valid = 1'b1;
        in_data  = 8'd255;
        in_last  = 1'b1;
        @(posedge clk);
        #1;
        check("long_valid", 16'(out_valid), 16'd1);
        check("long_err", 16'(out_err), 16'd1);
        check("long_class", 16'(out_class), 16'd1);
        check("long_hold_ready", 16'(in_ready), 16'd0);
        check("long_feats", 16'(feats()), 16'(14'b01_01_01_01_01_01_01));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("long_exit_valid", 16'(out_valid), 16'd0);
        check("long_exit_ready", 16'(in_ready), 16'd1);
        check("long_exit_no_accept", 16'(feats()), 16'(14'b01_01_01_01_01_01_01));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        expect_result("eighth", 14'b01_01_01_01_01_01_11, 1'b0, 1'b1, 0);

        // reset after three samples of a frame
        for (int i = 0; i < 3; i++) send(8'd255, 1'b0, 0);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_in_ready", 16'(in_ready), 16'd0);
        check("mid_rst_out_valid", 16'(out_valid), 16'd0);
        check("mid_rst_out_class", 16'(out_class), 16'd0);
        check("mid_rst_out_err", 16'(out_err), 16'd0);
        check("mid_rst_feats", 16'(feats()), 16'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_post_rst_ready", 16'(in_ready), 16'd1);
        for (int i = 0; i < 7; i++) send(f1[i], i == 6, 0);
        expect_result("after_rst", 14'b11_01_00_11_10_01_00, 1'b1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
